// File: rtl/gshare_bpu.sv
// gshare direction predictor: PC-xor-history indexed saturating counters,
// speculative GHR with mispredict recovery, and a sequential table clear.
module gshare_bpu #(
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned HIST_W   = 4,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned PC_SHIFT = 0,
  parameter int unsigned INIT     = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lookup_valid_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              pred_taken_o,
  output logic [HIST_W-1:0] pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic [HIST_W-1:0] upd_ghr_i,
  input  logic              upd_taken_i,
  input  logic              upd_mispredict_i,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic [HIST_W-1:0] ghr_o,
  output logic [15:0]       mispred_cnt_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [CTR_W-1:0]  ctr_q [DEPTH];

  logic              busy;
  logic              upd_en;
  logic              pred;
  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [CTR_W-1:0]  up_old, up_new, lk_ctr;
  logic              unused_pc;

  assign busy   = (state_q == ST_CLEAR);
  assign lk_idx = lookup_pc_i[PC_SHIFT +: IDX_W] ^ IDX_W'(ghr_q);
  assign up_idx = upd_pc_i[PC_SHIFT +: IDX_W] ^ IDX_W'(upd_ghr_i);
  // A clear request in the same cycle as an update drops the update.
  assign upd_en = upd_valid_i && !busy && !clear_req_i;
  assign up_old = ctr_q[up_idx];

  always_comb begin
    up_new = up_old;
    if (upd_taken_i && up_old != CTR_MAX) begin
      up_new = up_old + CTR_W'(1);
    end else if (!upd_taken_i && up_old != '0) begin
      up_new = up_old - CTR_W'(1);
    end
  end

  // Same-cycle update to the looked-up entry is forwarded to the prediction.
  assign lk_ctr = (upd_en && up_idx == lk_idx) ? up_new : ctr_q[lk_idx];
  assign pred   = !busy && lk_ctr[CTR_W-1];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          ghr_d   = '0;
        end else if (upd_en && upd_mispredict_i) begin
          ghr_d = HIST_W'({upd_ghr_i, upd_taken_i});
        end else if (lookup_valid_i) begin
          ghr_d = HIST_W'({ghr_q, pred});
        end
        if (upd_en && upd_mispredict_i && cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ghr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (busy) begin
      ctr_q[ptr_q] <= CTR_INIT;
    end else if (upd_en) begin
      ctr_q[up_idx] <= up_new;
    end
  end

  assign unused_pc     = ^{lookup_pc_i, upd_pc_i};
  assign pred_taken_o  = pred;
  assign pred_ghr_o    = ghr_q;
  assign ghr_o         = ghr_q;
  assign busy_o        = busy;
  assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_gshare_bpu.sv
// Directed, table-driven bench for gshare_bpu at default parameters.
module tb_gshare_bpu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        pred_taken_o;
  logic [3:0]  pred_ghr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [3:0]  upd_ghr_i;
  logic        upd_taken_i;
  logic        upd_mispredict_i;
  logic        clear_req_i;
  logic        busy_o;
  logic [3:0]  ghr_o;
  logic [15:0] mispred_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  gshare_bpu dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lookup_valid_i   (lookup_valid_i),
    .lookup_pc_i      (lookup_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_ghr_i        (upd_ghr_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i),
    .clear_req_i      (clear_req_i),
    .busy_o           (busy_o),
    .ghr_o            (ghr_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        exp_pred;
  } vec_t;

  vec_t sat_tab[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("check %-14s act=%0h exp=%0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    lookup_valid_i   = 1'b0;
    lookup_pc_i      = '0;
    upd_valid_i      = 1'b0;
    upd_pc_i         = '0;
    upd_ghr_i        = '0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b0;
    clear_req_i      = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] g, input logic t, input logic m);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_ghr_i        = g;
    upd_taken_i      = t;
    upd_mispredict_i = m;
    cyc();
    upd_valid_i      = 1'b0;
    upd_mispredict_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    idle();
    rst_ni = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();
    chk("init_busy", 32'(busy_o), 32'd0);
    chk("init_ghr", 32'(ghr_o), 32'd0);
    chk("init_cnt", 32'(mispred_cnt_o), 32'd0);
    chk("init_pred", 32'(pred_taken_o), 32'd0);

    // Saturation at pc 0x5: counter 1,2,3,3 then 2,1,0,0,0 then 1,2.
    sat_tab[0]  = '{32'h5, 1'b1, 1'b0};
    sat_tab[1]  = '{32'h5, 1'b1, 1'b1};
    sat_tab[2]  = '{32'h5, 1'b1, 1'b1};
    sat_tab[3]  = '{32'h5, 1'b1, 1'b1};
    sat_tab[4]  = '{32'h5, 1'b0, 1'b1};
    sat_tab[5]  = '{32'h5, 1'b0, 1'b0};
    sat_tab[6]  = '{32'h5, 1'b0, 1'b0};
    sat_tab[7]  = '{32'h5, 1'b0, 1'b0};
    sat_tab[8]  = '{32'h5, 1'b0, 1'b0};
    sat_tab[9]  = '{32'h5, 1'b1, 1'b0};
    sat_tab[10] = '{32'h5, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      upd(sat_tab[i].pc, 4'h0, sat_tab[i].taken, 1'b0);
      lookup_pc_i = sat_tab[i].pc;
      #1;
      chk($sformatf("sat_%0d", i), 32'(pred_taken_o), 32'(sat_tab[i].exp_pred));
    end

    // Dirty the state: one mispredict (ghr recovers to 0), then a speculative shift.
    upd(32'h0, 4'h0, 1'b0, 1'b1);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = 32'h5;
    cyc();
    lookup_valid_i = 1'b0;
    chk("dirty_ghr", 32'(ghr_o), 32'd1);
    chk("dirty_cnt", 32'(mispred_cnt_o), 32'd1);

    // Asynchronous mid-run reset.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_ghr", 32'(ghr_o), 32'd0);
    chk("arst_cnt", 32'(mispred_cnt_o), 32'd0);
    cyc();
    rst_ni = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pred_ghr", 32'(pred_ghr_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc_i = 32'(i);
      #1;
      chk($sformatf("rst_entry_%0d", i), 32'(pred_taken_o), 32'd0);
    end

    // Forwarding at index 3.
    upd(32'h3, 4'h0, 1'b1, 1'b0);
    lookup_pc_i = 32'h3;
    #1;
    chk("fwd_pre", 32'(pred_taken_o), 32'd0);
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h3;
    upd_ghr_i   = 4'h0;
    upd_taken_i = 1'b1;
    #1;
    chk("fwd_same", 32'(pred_taken_o), 32'd1);
    cyc();
    upd_valid_i = 1'b0;
    #1;
    chk("fwd_after", 32'(pred_taken_o), 32'd1);

    // GHR shift then recovery.
    repeat (3) upd(32'h6, 4'h0, 1'b1, 1'b0);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = 32'h6;
    #1;
    chk("ghr_pred", 32'(pred_taken_o), 32'd1);
    cyc();
    chk("ghr_shift", 32'(ghr_o), 32'h1);
    chk("ghr_pred_ghr", 32'(pred_ghr_o), 32'h1);
    lookup_pc_i = 32'h0;
    upd(32'h0, 4'b1010, 1'b0, 1'b1);
    lookup_valid_i = 1'b0;
    chk("ghr_recover", 32'(ghr_o), 32'b0100);
    chk("ghr_cnt", 32'(mispred_cnt_o), 32'd1);

    // Clear: train counter[9], set ghr, then clear with colliding update.
    do_reset();
    upd(32'h0, 4'h0, 1'b0, 1'b1);
    repeat (3) upd(32'h9, 4'h0, 1'b1, 1'b0);
    lookup_valid_i = 1'b1;
    lookup_pc_i    = 32'h9;
    #1;
    chk("clr_pre_pred", 32'(pred_taken_o), 32'd1);
    cyc();
    chk("clr_pre_ghr", 32'(ghr_o), 32'd1);
    clear_req_i      = 1'b1;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 32'h9;
    upd_ghr_i        = 4'h0;
    upd_taken_i      = 1'b1;
    upd_mispredict_i = 1'b1;
    cyc();
    clear_req_i = 1'b0;
    chk("clr_busy", 32'(busy_o), 32'd1);
    chk("clr_ghr0", 32'(ghr_o), 32'd0);
    chk("clr_drop_cnt", 32'(mispred_cnt_o), 32'd1);
    n = 0;
    while (busy_o && n < 40) begin
      n++;
      if (n == 1) chk("clr_pred_off", 32'(pred_taken_o), 32'd0);
      cyc();
    end
    idle();
    chk("clr_len", 32'(n), 32'd16);
    chk("clr_post_ghr", 32'(ghr_o), 32'd0);
    chk("clr_post_cnt", 32'(mispred_cnt_o), 32'd1);
    lookup_pc_i = 32'h9;
    #1;
    chk("clr_entry9", 32'(pred_taken_o), 32'd0);
    upd(32'h9, 4'h0, 1'b1, 1'b0);
    #1;
    chk("clr_entry9_up", 32'(pred_taken_o), 32'd0);

    // Reset in the middle of a clear aborts it.
    clear_req_i = 1'b1;
    cyc();
    clear_req_i = 1'b0;
    repeat (5) cyc();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("abort_stay", 32'(busy_o), 32'd0);

    // Mispredict counter saturation.
    do_reset();
    upd_valid_i      = 1'b1;
    upd_pc_i         = 32'h0;
    upd_ghr_i        = 4'h0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b1;
    repeat (65534) cyc();
    chk("msat_fffe", 32'(mispred_cnt_o), 32'hFFFE);
    cyc();
    chk("msat_ffff", 32'(mispred_cnt_o), 32'hFFFF);
    cyc();
    chk("msat_hold", 32'(mispred_cnt_o), 32'hFFFF);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
